// File: rtl/novacore_cfg_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// novacore_cfg_pkg : shared types/constants for the NovaCORE config loader.
// Rev 1.0
// ------------------------------------------------------------------------
package novacore_cfg_pkg;

  localparam int DEF_BUS_W     = 74;
  localparam int DEF_UID_W     = 9;
  localparam int DEF_NUM_CELLS = 81;
  localparam int DEF_IN_W      = 32;

  function automatic int calc_wpf(input int bus_w, input int in_w);
    return (bus_w + in_w - 1) / in_w;
  endfunction

  localparam int WPF = calc_wpf(DEF_BUS_W, DEF_IN_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_CHECK = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/novacore_cfg_loader_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// novacore_cfg_loader_if : input word stream plus fabric config port.
// Rev 1.0
// ------------------------------------------------------------------------
interface novacore_cfg_loader_if
  import novacore_cfg_pkg::*;
#(
  parameter int BUS_W = DEF_BUS_W,
  parameter int UID_W = DEF_UID_W,
  parameter int IN_W  = DEF_IN_W
) ();
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [BUS_W-1:0] c_bus;
  logic [UID_W-1:0] c_uid;
  logic             c_clk;

  modport master (
    input  in_data, in_valid,
    output in_ready, mode, c_bus, c_uid, c_clk
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mode, c_bus, c_uid, c_clk
  );
endinterface
`default_nettype wire

// File: rtl/novacore_cfg_frame_asm.sv
`default_nettype none
// ------------------------------------------------------------------------
// novacore_cfg_frame_asm : packs IN_W-bit words into a BUS_W-bit frame.
// Rev 1.0
// ------------------------------------------------------------------------
module novacore_cfg_frame_asm
  import novacore_cfg_pkg::*;
#(
  parameter int BUS_W = DEF_BUS_W,
  parameter int IN_W  = DEF_IN_W,
  parameter int WPF_N = calc_wpf(BUS_W, IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [IN_W-1:0]  word_i,
  input  logic             wr_i,
  output logic [BUS_W-1:0] frame_o,
  output logic             full_o
);
  localparam int              CNT_W    = (WPF_N > 1) ? $clog2(WPF_N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WPF_N - 1);

  logic [CNT_W-1:0] cnt_q;

  // full_o flags the write that completes the frame
  assign full_o = wr_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (clr_i)
      cnt_q <= '0;
    else if (wr_i)
      cnt_q <= full_o ? '0 : cnt_q + CNT_W'(1);
  end

  generate
    for (genvar k = 0; k < WPF_N; k++) begin : g_slot
      localparam int LO = k * IN_W;
      localparam int SW = ((BUS_W - LO) < IN_W) ? (BUS_W - LO) : IN_W;
      logic [SW-1:0] slot_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          slot_q <= '0;
        else if (wr_i && (cnt_q == CNT_W'(k)))
          slot_q <= word_i[SW-1:0];
      end

      assign frame_o[LO +: SW] = slot_q;
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/novacore_cfg_loader.sv
`default_nettype none
// ------------------------------------------------------------------------
// novacore_cfg_loader : streams packed frames into the array, one c_clk per
// cell. Define CFG_CHECKSUM_EN for a trailing sum-word check. Rev 1.0
// ------------------------------------------------------------------------
module novacore_cfg_loader
  import novacore_cfg_pkg::*;
#(
  parameter int BUS_W     = DEF_BUS_W,
  parameter int UID_W     = DEF_UID_W,
  parameter int NUM_CELLS = DEF_NUM_CELLS,
  parameter int IN_W      = DEF_IN_W,
  parameter int CLK_DIV   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  novacore_cfg_loader_if.master cfg,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [UID_W-1:0]      cell_cnt_o
);
  localparam int               WPF_L    = calc_wpf(BUS_W, IN_W);
  localparam int               TMR_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [UID_W-1:0] UID_LAST = UID_W'(NUM_CELLS - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [UID_W-1:0] uid_q, uid_d;
  logic [UID_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             cclk_q, done_q;

  logic             w_xfer, w_wr, w_full, w_clr, w_tmr_end;
  logic [BUS_W-1:0] w_frame;

`ifdef CFG_CHECKSUM_EN
  logic [IN_W-1:0]  sum_q;
  assign cfg.in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
  assign cfg.in_ready = (state_q == ST_LOAD);
`endif

  assign w_xfer    = cfg.in_valid && cfg.in_ready;
  assign w_wr      = w_xfer && (state_q == ST_LOAD);
  assign w_tmr_end = (tmr_q == TMR_LAST);

  novacore_cfg_frame_asm #(
    .BUS_W (BUS_W),
    .IN_W  (IN_W),
    .WPF_N (WPF_L)
  ) u_frame (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (w_clr),
    .word_i  (cfg.in_data),
    .wr_i    (w_wr),
    .frame_o (w_frame),
    .full_o  (w_full)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    uid_d   = uid_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    w_clr   = 1'b0;
    if (abort_i) begin
      // abort outranks start and drops any partly assembled frame
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        w_clr   = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_LOAD;
            mode_d  = 1'b1;
            err_d   = 1'b0;
            uid_d   = '0;
            cnt_d   = '0;
            w_clr   = 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_full) begin
            state_d = ST_SETUP;
            tmr_d   = '0;
          end
        end
        ST_SETUP: begin
          if (w_tmr_end) begin
            state_d = ST_HIGH;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_HIGH: begin
          if (w_tmr_end) begin
            state_d = ST_HOLD;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_HOLD: begin
          if (w_tmr_end) begin
            tmr_d = '0;
            cnt_d = cnt_q + UID_W'(1);
            if (uid_q == UID_LAST) begin
`ifdef CFG_CHECKSUM_EN
              state_d = ST_CHECK;
`else
              state_d = ST_FIN;
`endif
            end else begin
              uid_d   = uid_q + UID_W'(1);
              state_d = ST_LOAD;
            end
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
`ifdef CFG_CHECKSUM_EN
        ST_CHECK: begin
          if (w_xfer) begin
            if (cfg.in_data == sum_q) begin
              state_d = ST_FIN;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
`endif
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d == ST_FIN)
      mode_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      uid_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b1;
      err_q   <= 1'b0;
      cclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      uid_q   <= uid_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      cclk_q  <= (state_d == ST_HIGH);
      done_q  <= (state_d == ST_FIN);
    end
  end

`ifdef CFG_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum_q <= '0;
    else if (state_q == ST_IDLE)
      sum_q <= '0;
    else if (w_wr)
      sum_q <= sum_q + cfg.in_data;
  end
`endif

  assign cfg.mode   = mode_q;
  assign cfg.c_bus  = w_frame;
  assign cfg.c_uid  = uid_q;
  assign cfg.c_clk  = cclk_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign cell_cnt_o = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_novacore_cfg_loader.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_novacore_cfg_loader : table-driven load scenarios plus reset corners.
// Rev 1.0
// ------------------------------------------------------------------------
module tb_novacore_cfg_loader;

  typedef struct {
    int gap_max;
    int abort_uid;
    int spur_uid;
    int csum_bad;
    int exp_pulses;
    int exp_cnt;
    int exp_short;
    int exp_done;
  } scen_t;

  typedef struct {
    int          uid;
    logic [73:0] bus;
  } frm_t;

`ifdef CFG_CHECKSUM_EN
  localparam int NSCEN = 6;
`else
  localparam int NSCEN = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] cell_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  novacore_cfg_loader_if #(.BUS_W(74), .UID_W(9), .IN_W(32)) cfg_if ();

  novacore_cfg_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .cfg        (cfg_if),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .cell_cnt_o (cell_cnt)
  );

  always #5 clk = ~clk;

  // frame u is built from words u, u+1, u+2
  function automatic logic [73:0] exp_frame(input int u);
    logic [31:0] a, b, c;
    a = 32'(u);
    b = 32'(u + 1);
    c = 32'(u + 2);
    return {c[9:0], b, a};
  endfunction

  int          pulses = 0, uid_bad = 0, bus_bad = 0, hi_chg = 0, short_w = 0, done_seen = 0;
  int          exp_uid = 0, hi_len = 0;
  logic        prev_cclk = 1'b0;
  logic [73:0] held_bus;
  logic [73:0] cap_bus [0:80];

  always @(negedge clk) begin
    if (!busy) exp_uid = 0;
    if (cfg_if.c_clk && !prev_cclk) begin
      pulses++;
      if (int'(cfg_if.c_uid) != exp_uid) uid_bad++;
      if (cfg_if.c_bus != exp_frame(int'(cfg_if.c_uid))) bus_bad++;
      if (cfg_if.c_uid < 9'd81) cap_bus[cfg_if.c_uid] = cfg_if.c_bus;
      held_bus = cfg_if.c_bus;
      hi_len   = 1;
      exp_uid++;
    end else if (cfg_if.c_clk) begin
      hi_len++;
      if (cfg_if.c_bus != held_bus) hi_chg++;
    end else if (prev_cclk) begin
      if (hi_len != 2) short_w++;
    end
    if (done) done_seen++;
    prev_cclk = cfg_if.c_clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit spur, output bit ok);
    int t;
    ok = 1'b1;
    repeat ($urandom_range(0, gap)) begin
      cfg_if.in_valid = 1'b0;
      @(negedge clk);
    end
    cfg_if.in_valid = 1'b1;
    cfg_if.in_data  = w;
    if (spur) start_i = 1'b1;
    t = 0;
    while (!cfg_if.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      bound_fail("in_ready_wait");
      ok = 1'b0;
    end
    @(negedge clk);
    cfg_if.in_valid = 1'b0;
    start_i         = 1'b0;
  endtask

  task automatic run_load(input scen_t s);
    int          p0, ub0, bb0, hc0, sw0, d0, t;
    bit          ok, aborted;
    logic [31:0] sum;
    p0 = pulses; ub0 = uid_bad; bb0 = bus_bad; hc0 = hi_chg; sw0 = short_w; d0 = done_seen;
    sum = '0; ok = 1'b1; aborted = 1'b0;

    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_mode", cfg_if.mode, 1);
    chk("start_busy", busy, 1);
    chk("start_uid", cfg_if.c_uid, 0);
    chk("start_cnt", cell_cnt, 0);
    chk("start_err", err, 0);

    for (int u = 0; u < 81 && ok && !aborted; u++) begin
      for (int k = 0; k < 3 && ok; k++) begin
        send_word(32'(u + k), s.gap_max, (u == s.spur_uid) && (k == 0), ok);
        sum = sum + 32'(u + k);
      end
      if (u == s.abort_uid && ok) begin
        t = 0;
        while (!cfg_if.c_clk && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (t >= 50) bound_fail("abort_strobe_wait");
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_cclk", cfg_if.c_clk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mode", cfg_if.mode, 1);
        chk("abort_done", done, 0);
        chk("abort_cnt", cell_cnt, 128'(s.exp_cnt));
        aborted = 1'b1;
      end
    end

    if (!aborted && ok) begin
`ifdef CFG_CHECKSUM_EN
      send_word(sum + 32'(s.csum_bad), 0, 1'b0, ok);
      if (s.csum_bad != 0) begin
        chk("csum_err", err, 1);
        chk("csum_mode", cfg_if.mode, 1);
        chk("csum_busy", busy, 0);
        chk("csum_cnt", cell_cnt, 128'(s.exp_cnt));
      end else begin
`else
      begin
`endif
        t = 0;
        while (!done && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("done_pulse", done, 1);
        chk("fin_mode", cfg_if.mode, 0);
        chk("fin_cnt", cell_cnt, 128'(s.exp_cnt));
        chk("fin_err", err, 0);
        @(negedge clk);
        chk("done_1cyc", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_mode", cfg_if.mode, 0);
      end
    end
    @(negedge clk);
    chk("pulses", pulses - p0, 128'(s.exp_pulses));
    chk("uid_order_errs", uid_bad - ub0, 0);
    chk("frame_errs", bus_bad - bb0, 0);
    chk("bus_chg_hi", hi_chg - hc0, 0);
    chk("short_pulses", short_w - sw0, 128'(s.exp_short));
    chk("done_count", done_seen - d0, 128'(s.exp_done));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  scen_t tbl [NSCEN];
  frm_t  ftbl [3];

  initial begin
    bit ok;
    int t;
    //            gap abort spur bad puls cnt short done
    tbl[0] = '{0, -1, -1, 0, 81, 81, 0, 1};
    tbl[1] = '{5, -1, -1, 0, 81, 81, 0, 1};
    tbl[2] = '{0, 40, -1, 0, 41, 40, 1, 0};
    tbl[3] = '{2, -1, 10, 0, 81, 81, 0, 1};
`ifdef CFG_CHECKSUM_EN
    tbl[4] = '{0, -1, -1, 1, 81, 81, 0, 0};
    tbl[5] = '{0, -1, -1, 0, 81, 81, 0, 1};
`endif
    ftbl[0] = '{0,  {10'd2,  32'd1,  32'd0}};
    ftbl[1] = '{5,  {10'd7,  32'd6,  32'd5}};
    ftbl[2] = '{80, {10'd82, 32'd81, 32'd80}};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    cfg_if.in_valid = 1'b0; cfg_if.in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_mode", cfg_if.mode, 1);
    chk("rst_cclk", cfg_if.c_clk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cell_cnt, 0);
    chk("rst_bus", cfg_if.c_bus, 0);
    chk("rst_uid", cfg_if.c_uid, 0);
    chk("rst_ready", cfg_if.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NSCEN; i++) begin
      run_load(tbl[i]);
      if (i == 0) begin
        for (int f = 0; f < 3; f++)
          chk($sformatf("frame_uid%0d", ftbl[f].uid), cap_bus[ftbl[f].uid], ftbl[f].bus);
      end
    end

    // async reset while uid 2 is strobing
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int u = 0; u < 3; u++)
      for (int k = 0; k < 3; k++)
        send_word(32'(u + k), 0, 1'b0, ok);
    t = 0;
    while (!cfg_if.c_clk && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) bound_fail("rst_strobe_wait");
    #2 rst = 1'b1;
    #1;
    chk("arst_cclk", cfg_if.c_clk, 0);
    chk("arst_mode", cfg_if.mode, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_bus", cfg_if.c_bus, 0);
    chk("arst_uid", cfg_if.c_uid, 0);
    chk("arst_cnt", cell_cnt, 0);
    chk("arst_ready", cfg_if.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mode", cfg_if.mode, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
